// File: rtl/wb_sharedbus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_sharedbus_arbiter
//
// Round-robin ownership controller for a Wishbone shared-bus interconnect.
// One master at a time owns the bus for a whole cyc cycle; when it lets go the
// next requester is granted on the same edge so there is no idle bubble. A
// watchdog aborts a strobe that no slave answers within `timeout` cycles by
// pulsing a forced error toward the owner.
//
// Parameters
//   numm     number of masters (2..8)
//   timeout  unanswered-strobe cycles before abort (0 disables the watchdog)
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   cyc       per-master cyc request
//   stb_s     stb of the currently granted master
//   ack_s     OR of slave ack on the shared bus
//   err_s     OR of slave err on the shared bus
//   gnt       one-hot grant, zero when idle
//   gnt_idx   index of the owner, holds the last owner when idle
//   bus_busy  a master owns the bus
//   tmo_err   one-cycle forced err toward the owner
//   tmo_cnt   saturating count of watchdog aborts
// -----------------------------------------------------------------------------
module wb_sharedbus_arbiter #(
  parameter int numm    = 2,
  parameter int timeout = 255,
  localparam int iw     = $clog2(numm)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [numm-1:0] cyc,
  input  logic            stb_s,
  input  logic            ack_s,
  input  logic            err_s,
  output logic [numm-1:0] gnt,
  output logic [iw-1:0]   gnt_idx,
  output logic            bus_busy,
  output logic            tmo_err,
  output logic [7:0]      tmo_cnt
);

  // The watchdog counter needs at least one bit even when the watchdog is off.
  localparam int cw = (timeout > 0) ? $clog2(timeout + 1) : 1;
  localparam logic [cw-1:0] tmoLast = cw'((timeout > 0) ? timeout - 1 : 0);

  typedef enum logic [1:0] {IDLE, OWNED, ABORT, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [numm-1:0]   gnt_q, gnt_d;
  logic [iw-1:0]     gntIdx_q, gntIdx_d;
  logic              busy_q, busy_d;
  logic              tmoErr_q, tmoErr_d;
  logic [7:0]        tmoCnt_q, tmoCnt_d;
  logic [iw-1:0]     ptr_q, ptr_d;
  logic [cw-1:0]     wdCnt_q, wdCnt_d;

  logic [2*numm-1:0] cycTwice;
  logic [numm-1:0]   cycRot;
  logic [iw:0]       scanSum;
  logic [iw-1:0]     win;
  logic              found;
  logic [iw-1:0]     nextPtr;
  logic              ownerCyc;
  logic              stall;
  logic              expire;
  logic              handOff;

  // Round-robin winner search. The request vector is rotated so that bit 0
  // corresponds to ptr; the first set bit of the rotated vector, mapped back
  // to an absolute index modulo numm, is the winner. Since the current owner
  // has always dropped its own cyc when this result is used for a hand-off,
  // the same search serves both a grant from idle and a back-to-back release.
  always_comb begin
    cycTwice = {cyc, cyc} >> ptr_q;
    cycRot   = cycTwice[numm-1:0];
    found    = 1'b0;
    win      = '0;
    scanSum  = '0;
    for (int k = 0; k < numm; k++) begin
      if (!found && cycRot[k]) begin
        found   = 1'b1;
        scanSum = {1'b0, ptr_q} + (iw+1)'(k);
        if (scanSum >= (iw+1)'(numm)) begin
          scanSum = scanSum - (iw+1)'(numm);
        end
        win = scanSum[iw-1:0];
      end
    end
    nextPtr = (win == iw'(numm - 1)) ? '0 : win + iw'(1);
  end

  // Watchdog: a cycle counts as stalled only while the bus is normally owned
  // and the strobe is unanswered; anything else restarts the count. Hitting
  // the limit clears the counter itself since the FSM leaves OWNED anyway.
  always_comb begin
    ownerCyc = cyc[gntIdx_q];
    stall    = (state_q == OWNED) && stb_s && !(ack_s || err_s);
    expire   = (timeout != 0) && stall && (wdCnt_q == tmoLast);
    wdCnt_d  = (stall && !expire) ? wdCnt_q + cw'(1) : '0;
  end

  // Ownership FSM. A release in OWNED or DRAIN re-uses the winner search so
  // the next master is granted on the very edge the owner lets go. ABORT
  // always lasts exactly one cycle, whatever the owner or slaves do.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gntIdx_d = gntIdx_q;
    busy_d   = busy_q;
    tmoErr_d = 1'b0;
    tmoCnt_d = tmoCnt_q;
    ptr_d    = ptr_q;
    handOff  = 1'b0;

    case (state_q)
      IDLE: begin
        handOff = found;
      end
      OWNED: begin
        if (!ownerCyc) begin
          handOff = 1'b1;
        end else if (expire) begin
          state_d  = ABORT;
          tmoErr_d = 1'b1;
          tmoCnt_d = (tmoCnt_q == 8'hFF) ? 8'hFF : tmoCnt_q + 8'd1;
        end
      end
      ABORT: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        handOff = !ownerCyc;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (handOff) begin
      if (found) begin
        state_d  = OWNED;
        gnt_d    = {{(numm-1){1'b0}}, 1'b1} << win;
        gntIdx_d = win;
        busy_d   = 1'b1;
        ptr_d    = nextPtr;
      end else begin
        state_d  = IDLE;
        gnt_d    = '0;
        busy_d   = 1'b0;
      end
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gntIdx_q <= '0;
      busy_q   <= 1'b0;
      tmoErr_q <= 1'b0;
      tmoCnt_q <= '0;
      ptr_q    <= '0;
      wdCnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gntIdx_q <= gntIdx_d;
      busy_q   <= busy_d;
      tmoErr_q <= tmoErr_d;
      tmoCnt_q <= tmoCnt_d;
      ptr_q    <= ptr_d;
      wdCnt_q  <= wdCnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_idx  = gntIdx_q;
  assign bus_busy = busy_q;
  assign tmo_err  = tmoErr_q;
  assign tmo_cnt  = tmoCnt_q;

endmodule
